// File: rtl/mult_shift_add_seq.sv
// Sequential shift-add multiplier: one row of WIDTH multiply-add cells reused
// once per multiplier bit, accumulating an unsigned 2*WIDTH-bit product.

module mult_add_cell (
  input  logic i_mk,
  input  logic i_q,
  input  logic i_ppi,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_pp;

  assign w_pp   = i_mk & i_q;
  assign o_sum  = w_pp ^ i_ppi ^ i_cin;
  assign o_cout = (w_pp & i_ppi) | (w_pp & i_cin) | (i_ppi & i_cin);

endmodule

module mult_shift_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_q;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH:0]       w_c;
  logic [2*WIDTH-1:0]   w_step;

  assign w_c[0] = 1'b0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_row
    mult_add_cell u_cell (
      .i_mk   (r_m[g]),
      .i_q    (r_q[0]),
      .i_ppi  (r_a[g]),
      .i_cin  (w_c[g]),
      .o_sum  (w_sum[g]),
      .o_cout (w_c[g+1])
    );
  end

  // Right shift of {C, sum, Qr}; the consumed multiplier bit Qr[0] falls off.
  assign w_step = {w_c[WIDTH], w_sum, r_q[WIDTH-1:1]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m     <= i_multiplicand;
            r_q     <= i_multiplier;
            r_a     <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          {r_a, r_q} <= w_step;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_product <= w_step;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == S_RUN);
  assign o_done    = (r_state == S_DONE);
  assign o_product = r_product;

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Directed self-checking bench for mult_shift_add_seq at WIDTH=4.

module tb_mult_shift_add_seq;

  localparam int W = 4;

  logic           clock;
  logic           reset;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mult_shift_add_seq #(.WIDTH(W)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_start        (start),
    .i_multiplicand (mcand),
    .i_multiplier   (mplier),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Present a start for exactly one rising edge; returns at the following negedge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(negedge clock);
    start  = 1'b0;
    mcand  = ~a;
    mplier = ~b;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    mcand = '0;
    mplier = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, done, product} !== {2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
  endtask

  task automatic test_max;
    do_start(4'hF, 4'hF);
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL max_busy[%0d]: busy=%b done=%b, want 1 0", k, busy, done);
      end
      @(negedge clock);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || product !== 8'hE1) begin
      n_fail++;
      $display("FAIL max_done: busy=%b done=%b product=%h, want 0 1 e1", busy, done, product);
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'hE1) begin
      n_fail++;
      $display("FAIL max_idle: busy=%b done=%b product=%h, want 0 0 e1", busy, done, product);
    end
  endtask

  task automatic test_exhaustive;
    int n_done = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] exp_p;
        bit got = 0;
        exp_p = 8'(a * b);
        do_start(4'(a), 4'(b));
        for (int t = 0; t < 12; t++) begin
          if (done === 1'b1) begin got = 1; break; end
          @(negedge clock);
        end
        if (got) n_done++;
        n_checks++;
        if (!got || product !== exp_p) begin
          n_fail++;
          $display("FAIL exh %0d*%0d: done_seen=%0d product=%h, want %h", a, b, got, product, exp_p);
        end
        @(negedge clock);
      end
    end
    n_checks++;
    if (n_done != 256) begin
      n_fail++;
      $display("FAIL exh_done_count: got %0d, want 256", n_done);
    end
  endtask

  task automatic test_hold;
    bit got;
    do_start(4'h0, 4'hB);
    got = 0;
    for (int t = 0; t < 12; t++) begin
      if (done === 1'b1) begin got = 1; break; end
      @(negedge clock);
    end
    n_checks++;
    if (!got || product !== 8'h00) begin
      n_fail++;
      $display("FAIL hold_first: done_seen=%0d product=%h, want 00", got, product);
    end
    @(negedge clock);
    do_start(4'h9, 4'h1);
    got = 0;
    for (int t = 0; t < 12; t++) begin
      if (done === 1'b1) begin got = 1; break; end
      n_checks++;
      if (product !== 8'h00) begin
        n_fail++;
        $display("FAIL hold_during_run[%0d]: product=%h, want 00", t, product);
      end
      @(negedge clock);
    end
    n_checks++;
    if (!got || product !== 8'h09) begin
      n_fail++;
      $display("FAIL hold_second: done_seen=%0d product=%h, want 09", got, product);
    end
    @(negedge clock);
  endtask

  task automatic test_ignore_start;
    int n_done = 0;
    do_start(4'h7, 4'h6);
    start  = 1'b1;
    mcand  = 4'hF;
    mplier = 4'hF;
    @(negedge clock);
    start = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (done === 1'b1) n_done++;
      @(negedge clock);
    end
    n_checks++;
    if (n_done != 1 || product !== 8'h2A) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d product=%h, want 1 2a", n_done, product);
    end
  endtask

  task automatic test_reset_mid_run;
    bit got;
    do_start(4'hD, 4'hE);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b product=%h, want 0 0 00", busy, done, product);
    end
    got = 0;
    for (int t = 0; t < 8; t++) begin
      if (done === 1'b1 || busy === 1'b1) got = 1;
      @(negedge clock);
    end
    n_checks++;
    if (got) begin
      n_fail++;
      $display("FAIL reset_no_done: activity after reset=%0d, want 0", got);
    end
    do_start(4'h3, 4'h5);
    got = 0;
    for (int t = 0; t < 12; t++) begin
      if (done === 1'b1) begin got = 1; break; end
      @(negedge clock);
    end
    n_checks++;
    if (!got || product !== 8'h0F) begin
      n_fail++;
      $display("FAIL reset_restart: done_seen=%0d product=%h, want 0f", got, product);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int t_done[$];
    start  = 1'b1;
    mcand  = 4'h5;
    mplier = 4'h5;
    for (int t = 0; t < 30 && t_done.size() < 3; t++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        t_done.push_back(cyc);
        n_checks++;
        if (product !== 8'h19) begin
          n_fail++;
          $display("FAIL b2b_product: product=%h, want 19", product);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (t_done.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d, want 3", t_done.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (t_done[i] - t_done[i-1] != W + 2) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", i, t_done[i] - t_done[i-1], W + 2);
        end
      end
    end
    repeat (W + 3) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_max();
    test_exhaustive();
    test_hold();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
